// File: rtl/updown_counter_5bit_if.sv
// Control/status bundle for the up/down modulus counter.
// master drives requests and load data; slave is the counter itself.
interface updown_counter_5bit_if #(
  parameter int unsigned WIDTH = 5
);
  logic             start;
  logic             stop;
  logic             en;
  logic             mode;
  logic             oneshot;
  logic [WIDTH-1:0] limit;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, en, mode, oneshot, limit, load, din,
    input  count, tc, busy, done
  );

  modport slave (
    input  start, stop, en, mode, oneshot, limit, load, din,
    output count, tc, busy, done
  );
endinterface

// File: rtl/updown_counter_5bit.sv
// Up/down modulus counter with IDLE/RUN/DONE control, saturating parallel load,
// wrap or oneshot termination and registered tc/busy/done status.
module updown_counter_5bit #(
  parameter int unsigned WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  updown_counter_5bit_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] count_q, count_nx;
  logic [WIDTH-1:0] lim_q, lim_nx;
  logic             mode_q, mode_nx;
  logic             oneshot_q, oneshot_nx;
  logic             tc_q, tc_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;

  logic [WIDTH-1:0] step_operand;
  logic [WIDTH-1:0] step_sum;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;
  logic             at_term;

  // Single adder: down count adds the inverted one with carry-in set.
  always_comb begin
    step_operand = mode_q ? ~WIDTH'(1) : WIDTH'(1);
    step_sum     = count_q + step_operand + WIDTH'(mode_q);
    load_val     = (bus.din > lim_q) ? lim_q : bus.din;
    start_val    = mode_q ? lim_q : '0;
    term_val     = mode_q ? '0 : lim_q;
    at_term      = (count_q == term_val);
  end

  // Next state: stop steers the FSM, load owns count, start/step only when neither is active.
  always_comb begin
    state_nx   = state;
    count_nx   = count_q;
    lim_nx     = lim_q;
    mode_nx    = mode_q;
    oneshot_nx = oneshot_q;
    tc_nx      = 1'b0;

    if (bus.load) begin
      count_nx = load_val;
    end

    if (bus.stop) begin
      if (state != IDLE) begin
        state_nx = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.load) begin
            mode_nx    = bus.mode;
            oneshot_nx = bus.oneshot;
            lim_nx     = bus.limit;
            count_nx   = bus.mode ? bus.limit : '0;
            state_nx   = RUN;
          end
        end
        RUN: begin
          if (bus.en && !bus.load) begin
            if (at_term) begin
              tc_nx = 1'b1;
              if (oneshot_q) begin
                state_nx = DONE;
              end else begin
                count_nx = start_val;
              end
            end else begin
              count_nx = step_sum;
            end
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end

    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count_q   <= '0;
      lim_q     <= '1;
      mode_q    <= 1'b0;
      oneshot_q <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      count_q   <= count_nx;
      lim_q     <= lim_nx;
      mode_q    <= mode_nx;
      oneshot_q <= oneshot_nx;
      tc_q      <= tc_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_updown_counter_5bit.sv
// Directed bench for updown_counter_5bit: hand-computed vectors checked with
// immediate assertions after each rising edge.
module tb_updown_counter_5bit;

  localparam int unsigned WIDTH = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_c;
  logic exp_tc;

  updown_counter_5bit_if #(.WIDTH(WIDTH)) bus ();

  updown_counter_5bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int c, input logic t, input logic b, input logic d);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".tc"},    32'(bus.tc),    32'(t));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
  endtask

  initial begin
    int s1_exp[7];
    s1_exp = '{1, 2, 3, 4, 5, 0, 1};
    checks = 0;
    errors = 0;
    bus.start = 0; bus.stop = 0; bus.en = 0; bus.mode = 0; bus.oneshot = 0;
    bus.limit = '0; bus.load = 0; bus.din = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #4;
    chk_out("reset", 0, 0, 0, 0);
    #2 rst_n = 1'b1;

    // Scenario 1: up, wrap, limit 5; later start/limit/mode changes are ignored
    bus.limit = 5'd5; bus.mode = 0; bus.oneshot = 0; bus.start = 1; bus.en = 1;
    tick();
    chk_out("s1_start", 0, 0, 1, 0);
    bus.limit = 5'd2; bus.mode = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("s1_count%0d", i), 32'(bus.count), 32'(s1_exp[i]));
      chk($sformatf("s1_tc%0d", i), 32'(bus.tc), (i == 5) ? 32'd1 : 32'd0);
    end
    bus.start = 0; bus.stop = 1;
    tick();
    chk_out("s1_stop", 1, 0, 0, 0);
    bus.stop = 0;

    // Scenario 2: down, oneshot, limit 3
    bus.limit = 5'd3; bus.mode = 1; bus.oneshot = 1; bus.start = 1; bus.en = 1;
    tick();
    chk_out("s2_start", 3, 0, 1, 0);
    bus.start = 0;
    tick(); chk_out("s2_c2", 2, 0, 1, 0);
    tick(); chk_out("s2_c1", 1, 0, 1, 0);
    tick(); chk_out("s2_c0", 0, 0, 1, 0);
    tick(); chk_out("s2_term", 0, 1, 0, 1);
    tick(); chk_out("s2_idle", 0, 0, 0, 0);

    // Scenario 3: saturating load in RUN, then load together with stop
    bus.limit = 5'd7; bus.mode = 0; bus.oneshot = 0; bus.start = 1; bus.en = 1;
    tick(); chk_out("s3_start", 0, 0, 1, 0);
    bus.start = 0;
    tick(); tick(); chk_out("s3_c2", 2, 0, 1, 0);
    bus.load = 1; bus.din = 5'd20;
    tick(); chk_out("s3_load_sat", 7, 0, 1, 0);
    bus.load = 0; bus.en = 0;
    tick(); chk_out("s3_hold", 7, 0, 1, 0);
    bus.load = 1; bus.din = 5'd4; bus.stop = 1;
    tick(); chk_out("s3_load_stop", 4, 0, 0, 0);
    bus.load = 0; bus.stop = 0;
    tick(); chk_out("s3_idle", 4, 0, 0, 0);

    // Scenario 4: full-range up count with en toggling
    bus.limit = 5'd31; bus.mode = 0; bus.oneshot = 0; bus.start = 1; bus.en = 0;
    tick(); chk_out("s4_start", 0, 0, 1, 0);
    bus.start = 0;
    exp_c = 0;
    for (int i = 0; i < 68; i++) begin
      bus.en = (i % 2 == 0);
      tick();
      if (i % 2 == 0) begin
        exp_tc = (exp_c == 31);
        exp_c  = exp_tc ? 0 : exp_c + 1;
      end else begin
        exp_tc = 1'b0;
      end
      chk($sformatf("s4_count%0d", i), 32'(bus.count), 32'(exp_c));
      chk($sformatf("s4_tc%0d", i), 32'(bus.tc), 32'(exp_tc));
    end
    bus.en = 0; bus.stop = 1;
    tick(); bus.stop = 0;

    // Scenario 5: asynchronous reset mid-run, latched limit returns to all ones
    bus.limit = 5'd20; bus.mode = 0; bus.oneshot = 0; bus.start = 1; bus.en = 1;
    tick(); bus.start = 0;
    for (int i = 0; i < 9; i++) tick();
    chk_out("s5_c9", 9, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_out("s5_async", 0, 0, 0, 0);
    tick(); chk_out("s5_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    bus.en = 0; bus.load = 1; bus.din = 5'd25;
    tick(); chk_out("s5_load_nosat", 25, 0, 0, 0);
    bus.load = 0; bus.limit = 5'd12; bus.start = 1; bus.en = 1;
    tick(); chk_out("s5_restart", 0, 0, 1, 0);
    bus.start = 0;
    tick(); chk_out("s5_c1", 1, 0, 1, 0);
    bus.stop = 1; tick(); bus.stop = 0;

    // Scenario 6: stop coincides with terminal count in oneshot
    bus.limit = 5'd2; bus.mode = 0; bus.oneshot = 1; bus.start = 1; bus.en = 1;
    tick(); bus.start = 0;
    tick(); tick(); chk_out("s6_c2", 2, 0, 1, 0);
    bus.stop = 1;
    tick(); chk_out("s6_stop_term", 2, 0, 0, 0);
    bus.stop = 0;
    tick(); chk_out("s6_idle", 2, 0, 0, 0);
    bus.start = 1;
    tick(); chk_out("s6_restart", 0, 0, 1, 0);
    bus.start = 0; bus.stop = 1; tick(); bus.stop = 0;

    // Zero limit: wrap gives tc every enabled step, oneshot finishes on first step
    bus.limit = 5'd0; bus.mode = 0; bus.oneshot = 0; bus.start = 1; bus.en = 1;
    tick(); chk_out("z_start", 0, 0, 1, 0);
    bus.start = 0;
    tick(); chk_out("z_wrap1", 0, 1, 1, 0);
    tick(); chk_out("z_wrap2", 0, 1, 1, 0);
    bus.stop = 1; tick(); bus.stop = 0;
    bus.mode = 1; bus.oneshot = 1; bus.start = 1;
    tick(); chk_out("z_os_start", 0, 0, 1, 0);
    bus.start = 0;
    tick(); chk_out("z_os_done", 0, 1, 0, 1);
    tick(); chk_out("z_os_idle", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
